// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one downstream APB master port among NB_REQ upstream requesters.
// One transfer in flight; SETUP/ACCESS is regenerated downstream from captured request fields.
module apb_rr_arbiter #(
  parameter int unsigned NB_REQ         = 4,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  localparam int unsigned GW            = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic [NB_REQ-1:0]                             psel_i,
  input  logic [NB_REQ-1:0]                             penable_i,
  input  logic [NB_REQ-1:0]                             pwrite_i,
  input  logic [NB_REQ-1:0][APB_ADDR_WIDTH-1:0]         paddr_i,
  input  logic [NB_REQ-1:0][APB_DATA_WIDTH-1:0]         pwdata_i,
  output logic [NB_REQ-1:0][APB_DATA_WIDTH-1:0]         prdata_o,
  output logic [NB_REQ-1:0]                             pready_o,
  output logic [NB_REQ-1:0]                             pslverr_o,
  output logic                                          psel_o,
  output logic                                          penable_o,
  output logic                                          pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0]                     paddr_o,
  output logic [APB_DATA_WIDTH-1:0]                     pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0]                     prdata_i,
  input  logic                                          pready_i,
  input  logic                                          pslverr_i,
  output logic [GW-1:0]                                 grant_o,
  output logic                                          busy_o
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e                    state_q;
  logic [GW-1:0]             last_q;
  logic [GW-1:0]             grant_q;
  logic                      psel_q;
  logic                      penable_q;
  logic                      pwrite_q;
  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic [APB_DATA_WIDTH-1:0] pwdata_q;

  logic                      found;
  logic [GW-1:0]             winner;
  logic [GW-1:0]             cand;
  int unsigned               idx;
  logic                      done;

  // Only psel_i is a request; penable_i carries no information the arbiter needs.
  logic unused_penable;
  assign unused_penable = ^penable_i;

  // Scan last_q+1, last_q+2, ... modulo NB_REQ; first requester found wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    cand   = '0;
    for (int unsigned i = 1; i <= NB_REQ; i++) begin
      idx  = (32'(last_q) + i) % NB_REQ;
      cand = idx[GW-1:0];
      if (!found && psel_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      last_q    <= GW'(NB_REQ - 1);
      grant_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (found) begin
            last_q   <= winner;
            grant_q  <= winner;
            pwrite_q <= pwrite_i[winner];
            paddr_q  <= paddr_i[winner];
            pwdata_q <= pwdata_i[winner];
            psel_q   <= 1'b1;
            state_q  <= StSetup;
          end
        end
        StSetup: begin
          penable_q <= 1'b1;
          state_q   <= StAccess;
        end
        StAccess: begin
          if (pready_i) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

  // A reset landing on the completion cycle abandons the transfer, so no response escapes.
  assign done = (state_q == StAccess) && pready_i && !rst_i;

  always_comb begin
    pready_o  = '0;
    pslverr_o = '0;
    prdata_o  = '0;
    if (done) begin
      pready_o[grant_q]  = 1'b1;
      pslverr_o[grant_q] = pslverr_i;
      prdata_o[grant_q]  = prdata_i;
    end
  end

  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign busy_o    = psel_q;
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;
  assign grant_o   = grant_q;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Self-checking bench for apb_rr_arbiter: APB requester models, a stallable slave model and a
// per-requester scoreboard of expected downstream fields and responses.
module tb_apb_rr_arbiter;
  localparam int NB = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
  } xfer_t;

  logic                  clk = 1'b0;
  logic                  rst_i = 1'b1;
  logic [NB-1:0]         psel_i = '0;
  logic [NB-1:0]         penable_i = '0;
  logic [NB-1:0]         pwrite_i = '0;
  logic [NB-1:0][AW-1:0] paddr_i = '0;
  logic [NB-1:0][DW-1:0] pwdata_i = '0;
  logic [NB-1:0][DW-1:0] prdata_o;
  logic [NB-1:0]         pready_o;
  logic [NB-1:0]         pslverr_o;
  logic                  psel_o, penable_o, pwrite_o;
  logic [AW-1:0]         paddr_o;
  logic [DW-1:0]         pwdata_o;
  logic [DW-1:0]         prdata_i = '0;
  logic                  pready_i = 1'b0;
  logic                  pslverr_i = 1'b0;
  logic [1:0]            grant_o;
  logic                  busy_o;

  apb_rr_arbiter #(.NB_REQ(NB), .APB_DATA_WIDTH(DW), .APB_ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
    .paddr_i(paddr_i), .pwdata_i(pwdata_i),
    .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  xfer_t stim_q[NB][$];
  xfer_t exp_q[NB][$];
  xfer_t cur[NB];
  int    grant_log[$];
  int    done_cyc[$];
  logic [NB-1:0] active = '0;
  logic [NB-1:0] rdy_seen = '0;

  int fixed_wait = 0;
  bit rand_wait = 1'b0;
  int wait_n = 0;
  int acc_cnt = 0;

  // Slave rule: address 0x40 answers 0x1234_5678 with error, anything else answers ~addr, err=addr[2].
  function automatic xfer_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    xfer_t x;
    x.write = w;
    x.addr  = a;
    x.wdata = d;
    x.rdata = (a == 32'h40) ? 32'h1234_5678 : ~a;
    x.err   = (a == 32'h40) ? 1'b1 : a[2];
    return x;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Requester models and slave model, driven just after each rising edge.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < NB; k++) begin
      if (active[k] && rdy_seen[k]) active[k] = 1'b0;
      if (!active[k] && stim_q[k].size() > 0) begin
        cur[k] = stim_q[k].pop_front();
        exp_q[k].push_back(cur[k]);
        active[k]    = 1'b1;
        psel_i[k]    = 1'b1;
        penable_i[k] = 1'b0;
        pwrite_i[k]  = cur[k].write;
        paddr_i[k]   = cur[k].addr;
        pwdata_i[k]  = cur[k].wdata;
      end else if (active[k]) begin
        penable_i[k] = 1'b1;
      end else begin
        psel_i[k]    = 1'b0;
        penable_i[k] = 1'b0;
      end
    end
    if (psel_o && penable_o) begin
      pready_i = (acc_cnt >= wait_n);
      acc_cnt++;
    end else begin
      pready_i = 1'b0;
      acc_cnt  = 0;
      wait_n   = rand_wait ? int'($urandom_range(3, 0)) : fixed_wait;
    end
    prdata_i  = (paddr_o == 32'h40) ? 32'h1234_5678 : ~paddr_o;
    pslverr_i = (paddr_o == 32'h40) ? 1'b1 : paddr_o[2];
  end

  // Scoreboard, response isolation and downstream stability monitor.
  xfer_t         e;
  logic          iso_ok;
  logic          prev_psel = 1'b0;
  logic          prev_pwrite;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wdata;

  always @(negedge clk) begin
    rdy_seen = pready_o;
    if (!rst_i) begin
      iso_ok = 1'b1;
      for (int k = 0; k < NB; k++)
        if (!(busy_o && int'(grant_o) == k) &&
            (pready_o[k] !== 1'b0 || pslverr_o[k] !== 1'b0 || prdata_o[k] !== '0))
          iso_ok = 1'b0;
      total_cnt++;
      if (iso_ok) pass_cnt++;
      else $display("FAIL isolation: got pready=%b pslverr=%b busy=%b grant=%0d, required zero on non-granted",
                    pready_o, pslverr_o, busy_o, grant_o);
      for (int k = 0; k < NB; k++) begin
        if (pready_o[k] === 1'b1) begin
          total_cnt++;
          if (exp_q[k].size() == 0) begin
            $display("FAIL sb_unexpected: requester %0d got pready, required no outstanding pulse", k);
          end else begin
            e = exp_q[k].pop_front();
            if (paddr_o !== e.addr || pwrite_o !== e.write || pwdata_o !== e.wdata ||
                prdata_o[k] !== e.rdata || pslverr_o[k] !== e.err)
              $display("FAIL sb_req%0d: got addr=%h wr=%b wd=%h rd=%h err=%b, required addr=%h wr=%b wd=%h rd=%h err=%b",
                       k, paddr_o, pwrite_o, pwdata_o, prdata_o[k], pslverr_o[k],
                       e.addr, e.write, e.wdata, e.rdata, e.err);
            else pass_cnt++;
          end
          grant_log.push_back(k);
          done_cyc.push_back(cyc);
        end
      end
      if (psel_o === 1'b1 && prev_psel === 1'b1) begin
        total_cnt++;
        if (paddr_o !== prev_addr || pwrite_o !== prev_pwrite || pwdata_o !== prev_wdata)
          $display("FAIL stability: got addr=%h wr=%b wd=%h, required addr=%h wr=%b wd=%h",
                   paddr_o, pwrite_o, pwdata_o, prev_addr, prev_pwrite, prev_wdata);
        else pass_cnt++;
      end
    end
    prev_psel   = psel_o;
    prev_pwrite = pwrite_o;
    prev_addr   = paddr_o;
    prev_wdata  = pwdata_o;
  end

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && grant_log.size() < n; c++) @(negedge clk);
    if (grant_log.size() >= n) ok = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    total_cnt += 4;
    if (psel_o !== 1'b0 || penable_o !== 1'b0) $display("FAIL rst_psel: got %b%b required 00", psel_o, penable_o);
    else pass_cnt++;
    if (busy_o !== 1'b0 || grant_o !== 2'd0) $display("FAIL rst_busy: got busy=%b grant=%0d required 0/0", busy_o, grant_o);
    else pass_cnt++;
    if (pwrite_o !== 1'b0 || paddr_o !== '0 || pwdata_o !== '0)
      $display("FAIL rst_fields: got wr=%b addr=%h wd=%h required zeros", pwrite_o, paddr_o, pwdata_o);
    else pass_cnt++;
    if (pready_o !== '0 || pslverr_o !== '0 || prdata_o !== '0)
      $display("FAIL rst_resp: got pready=%b pslverr=%b required zeros", pready_o, pslverr_o);
    else pass_cnt++;
  endtask

  task automatic test_single();
    stim_q[1].push_back(mk(1'b1, 32'h1000_0010, 32'hDEAD_BEEF));
    @(negedge clk);
    total_cnt++;
    if (psel_o !== 1'b0) $display("FAIL t1_c0_psel: got %b required 0", psel_o); else pass_cnt++;
    @(negedge clk);
    total_cnt += 3;
    if (psel_o !== 1'b1 || penable_o !== 1'b0)
      $display("FAIL t1_c1_setup: got psel=%b penable=%b required 1/0", psel_o, penable_o);
    else pass_cnt++;
    if (grant_o !== 2'd1 || busy_o !== 1'b1) $display("FAIL t1_c1_grant: got %0d/%b required 1/1", grant_o, busy_o);
    else pass_cnt++;
    if (pwdata_o !== 32'hDEAD_BEEF || paddr_o !== 32'h1000_0010 || pwrite_o !== 1'b1)
      $display("FAIL t1_c1_fields: got wd=%h addr=%h wr=%b required deadbeef/10000010/1", pwdata_o, paddr_o, pwrite_o);
    else pass_cnt++;
    @(negedge clk);
    total_cnt += 2;
    if (penable_o !== 1'b1) $display("FAIL t1_c2_penable: got %b required 1", penable_o); else pass_cnt++;
    if (pready_o !== 4'b0010) $display("FAIL t1_c2_pready: got %b required 0010", pready_o); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (psel_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL t1_c3_idle: got psel=%b busy=%b required 0/0", psel_o, busy_o);
    else pass_cnt++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    int base, start;
    bit ok;
    do_reset();
    @(negedge clk);
    base  = grant_log.size();
    start = cyc + 1;
    for (int k = 0; k < NB; k++) stim_q[k].push_back(mk(1'b1, 32'h2000_0000 + 32'(k * 8), 32'hA000_0000 + 32'(k)));
    wait_log(base + 4, 40, ok);
    total_cnt++;
    if (!ok) begin
      $display("FAIL t2_timeout: got %0d completions required 4", grant_log.size() - base);
    end else begin
      pass_cnt++;
      for (int i = 0; i < 4; i++) begin
        total_cnt++;
        if (grant_log[base+i] != i || done_cyc[base+i] != start + 2 + 3 * i)
          $display("FAIL t2_order%0d: got req %0d at cycle %0d, required req %0d at cycle %0d",
                   i, grant_log[base+i], done_cyc[base+i] - start, i, 2 + 3 * i);
        else pass_cnt++;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fairness();
    int base, start;
    bit ok;
    int want[3];
    want = '{0, 2, 0};
    do_reset();
    @(negedge clk);
    base  = grant_log.size();
    start = cyc + 1;
    stim_q[0].push_back(mk(1'b0, 32'h3000_0000, 32'h0));
    stim_q[0].push_back(mk(1'b1, 32'h3000_0004, 32'h1111_2222));
    stim_q[2].push_back(mk(1'b1, 32'h3000_0100, 32'h3333_4444));
    wait_log(base + 3, 40, ok);
    total_cnt++;
    if (!ok) begin
      $display("FAIL t3_timeout: got %0d completions required 3", grant_log.size() - base);
    end else begin
      pass_cnt++;
      for (int i = 0; i < 3; i++) begin
        total_cnt++;
        if (grant_log[base+i] != want[i] || done_cyc[base+i] != start + 2 + 3 * i)
          $display("FAIL t3_order%0d: got req %0d at cycle %0d, required req %0d at cycle %0d",
                   i, grant_log[base+i], done_cyc[base+i] - start, want[i], 2 + 3 * i);
        else pass_cnt++;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wait_read();
    int pulses = 0;
    int pulse_at = -1;
    logic [NB-1:0] others = '0;
    fixed_wait = 4;
    stim_q[3].push_back(mk(1'b0, 32'h40, 32'h0));
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      others |= pready_o & 4'b0111;
      if (pready_o[3] === 1'b1) begin
        pulses++;
        pulse_at = i;
        total_cnt++;
        if (prdata_o[3] !== 32'h1234_5678 || pslverr_o[3] !== 1'b1)
          $display("FAIL t4_resp: got rd=%h err=%b required 12345678/1", prdata_o[3], pslverr_o[3]);
        else pass_cnt++;
      end
    end
    total_cnt += 2;
    if (pulses != 1 || pulse_at != 6)
      $display("FAIL t4_pulse: got %0d pulses at cycle %0d required 1 at cycle 6", pulses, pulse_at);
    else pass_cnt++;
    if (others !== '0) $display("FAIL t4_others: got %b required 000", others[2:0]); else pass_cnt++;
    fixed_wait = 0;
  endtask

  task automatic test_reset_mid();
    int base;
    bit ok;
    bit seen = 1'b0;
    int want[3];
    want = '{0, 2, 3};
    fixed_wait = 1000;
    stim_q[2].push_back(mk(1'b1, 32'h5000_0020, 32'h5555_AAAA));
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (penable_o === 1'b1) seen = 1'b1;
    end
    total_cnt++;
    if (!seen) $display("FAIL t5_access: got no ACCESS phase, required one"); else pass_cnt++;
    stim_q[0].push_back(mk(1'b1, 32'h5000_0000, 32'h0000_0001));
    stim_q[3].push_back(mk(1'b0, 32'h5000_0030, 32'h0));
    @(negedge clk);
    base = grant_log.size();
    fixed_wait = 0;
    rst_i    = 1'b1;
    pready_i = 1'b1;
    #1;
    total_cnt++;
    if (pready_o !== '0) $display("FAIL t5_rst_pulse: got pready=%b required 0000", pready_o); else pass_cnt++;
    @(negedge clk);
    rst_i = 1'b0;
    total_cnt++;
    if (psel_o !== 1'b0 || busy_o !== 1'b0 || pready_o !== '0 || grant_o !== 2'd0)
      $display("FAIL t5_after: got psel=%b busy=%b pready=%b grant=%0d required 0/0/0000/0",
               psel_o, busy_o, pready_o, grant_o);
    else pass_cnt++;
    wait_log(base + 3, 40, ok);
    total_cnt++;
    if (!ok) begin
      $display("FAIL t5_timeout: got %0d completions required 3", grant_log.size() - base);
    end else begin
      pass_cnt++;
      for (int i = 0; i < 3; i++) begin
        total_cnt++;
        if (grant_log[base+i] != want[i])
          $display("FAIL t5_order%0d: got req %0d required req %0d", i, grant_log[base+i], want[i]);
        else pass_cnt++;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stability();
    int base;
    bit ok;
    int reqs[3];
    reqs = '{0, 1, 3};
    rand_wait = 1'b1;
    base = grant_log.size();
    for (int n = 0; n < 6; n++)
      for (int j = 0; j < 3; j++)
        stim_q[reqs[j]].push_back(mk(1'($urandom_range(1, 0)), $urandom | 32'h1000_0000, $urandom));
    wait_log(base + 18, 600, ok);
    total_cnt++;
    if (!ok) $display("FAIL t6_timeout: got %0d completions required 18", grant_log.size() - base);
    else pass_cnt++;
    rand_wait = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit, required self-termination");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int left;
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_wait_read();
    test_reset_mid();
    test_stability();
    left = 0;
    for (int k = 0; k < NB; k++) left += exp_q[k].size() + stim_q[k].size();
    total_cnt++;
    if (left != 0) $display("FAIL drain: got %0d outstanding transfers required 0", left);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
